rename_free_list: RTL and testbench

- Circular free list of physical register tags; sits directly upstream of rename_record_table.
- Rename stage pulls a free physical register per cycle; the pair (arch reg, old preg) is then recorded in rename_record_table.
- Commit returns old pregs popped from rename_record_table via the release port.
- Single checkpoint of the allocation head for branch-mispredict recovery.

---
 rtl/rename_pkg.sv | 14 +
 rtl/rename_free_list_mem.sv | 19 +
 rtl/rename_free_list.sv | 103 ++++++++++
 tb/tb_rename_free_list.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, tag type and FSM encoding for the rename free list.
package rename_pkg;
    localparam int PREG_WIDTH = 6;
    localparam int NUM_PREGS  = 64;
    localparam int NUM_AREGS  = 32;
    localparam int DEPTH      = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W      = $clog2(DEPTH);

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [PTR_W:0]        cnt_t;

    typedef enum logic {FL_INIT, FL_RUN} fl_state_e;
endpackage

// File: rtl/rename_free_list_mem.sv
// Free-list tag storage: one write port, one asynchronous read port, no reset.
module rename_free_list_mem
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  ptr_t  waddr,
    input  preg_t wdata,
    input  ptr_t  raddr,
    output preg_t rdata
);
    preg_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rename_free_list.sv
// Circular free list of physical register tags with a single head checkpoint
// for mispredict recovery. INIT fills the list with tags NUM_AREGS..NUM_PREGS-1.
module rename_free_list
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      alloc_req,
    output logic      alloc_grant,
    output preg_t     alloc_preg,
    input  logic      release_valid,
    input  preg_t     release_preg,
    input  logic      ckpt_save,
    input  logic      recover,
    output logic      ready,
    output cnt_t      free_count,
    output logic      list_full,
    output logic      list_empty,
    output logic      overflow_err,
    output fl_state_e state_dbg
);
    fl_state_e state, state_next;
    ptr_t      head, head_next, tail, ckpt_head, init_cnt, spec_cnt;
    cnt_t      count, count_next;
    logic      overflow_q;
    logic      run, rel_accept, rel_drop, mem_we;
    preg_t     mem_wdata;

    // Handshake: alloc_req is a request with no hold obligation; a tag is consumed
    // only in a cycle where alloc_grant=1, and alloc_preg is meaningful only then.
    // release_valid has no back-pressure: a release arriving while full is dropped
    // and recorded in overflow_err.
    assign run         = (state == FL_RUN);
    assign alloc_grant = alloc_req && run && (count != '0) && !recover;
    assign rel_accept  = run && release_valid && (count != cnt_t'(DEPTH));
    assign rel_drop    = run && release_valid && (count == cnt_t'(DEPTH));
    assign spec_cnt    = head - ckpt_head;

    // During INIT the write port is owned by the fill sequence.
    assign mem_we    = !run || rel_accept;
    assign mem_wdata = run ? release_preg : preg_t'(NUM_AREGS) + preg_t'(init_cnt);

    always_comb begin
        head_next = head;
        if (run) begin
            if (recover) head_next = ckpt_head;
            else         head_next = head + ptr_t'(alloc_grant);
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            FL_INIT: begin
                count_next = count + cnt_t'(1);
                if (init_cnt == ptr_t'(DEPTH - 1)) state_next = FL_RUN;
            end
            FL_RUN: begin
                // Recovery hands the speculatively allocated span back to the list.
                if (recover) count_next = count + cnt_t'(spec_cnt) + cnt_t'(rel_accept);
                else         count_next = count - cnt_t'(alloc_grant) + cnt_t'(rel_accept);
            end
            default: state_next = FL_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FL_INIT;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            init_cnt   <= '0;
            ckpt_head  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            head  <= head_next;
            if (mem_we) tail <= tail + ptr_t'(1);
            if (!run) init_cnt <= init_cnt + ptr_t'(1);
            if (run && ckpt_save && !recover) ckpt_head <= head_next;
            if (rel_drop) overflow_q <= 1'b1;
        end
    end

    rename_free_list_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (tail),
        .wdata (mem_wdata),
        .raddr (head),
        .rdata (alloc_preg)
    );

    assign ready        = run;
    assign free_count   = count;
    assign list_full    = (count == cnt_t'(DEPTH));
    assign list_empty   = (count == '0);
    assign overflow_err = overflow_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_rename_free_list.sv
// Bench for rename_free_list: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then constrained random traffic.
module tb_rename_free_list;
    import rename_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n;
    logic      alloc_req, release_valid, ckpt_save, recover;
    preg_t     release_preg;
    logic      alloc_grant, ready, list_full, list_empty, overflow_err;
    preg_t     alloc_preg;
    cnt_t      free_count;
    fl_state_e state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model: exp_q is the ordered free list (front = next grant),
    // spec_q holds tags granted since the last checkpoint, oldest first.
    logic [PREG_WIDTH-1:0] exp_q[$];
    logic [PREG_WIDTH-1:0] spec_q[$];
    int   m_init_left = DEPTH;
    logic m_ovf       = 1'b0;

    always #5 clk = ~clk;

    rename_free_list dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alloc_req     (alloc_req),
        .alloc_grant   (alloc_grant),
        .alloc_preg    (alloc_preg),
        .release_valid (release_valid),
        .release_preg  (release_preg),
        .ckpt_save     (ckpt_save),
        .recover       (recover),
        .ready         (ready),
        .free_count    (free_count),
        .list_full     (list_full),
        .list_empty    (list_empty),
        .overflow_err  (overflow_err),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req     = 1'b0;
        release_valid = 1'b0;
        release_preg  = '0;
        ckpt_save     = 1'b0;
        recover       = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Compare against the model, then advance the model by the coming clock edge.
    always @(negedge clk) begin : cmp
        int   sz;
        logic ready_e, grant_e, acc;
        if (!reset_n) begin
            exp_q.delete();
            spec_q.delete();
            m_init_left = DEPTH;
            m_ovf       = 1'b0;
        end
        sz      = exp_q.size();
        ready_e = reset_n && (m_init_left == 0);
        grant_e = ready_e && alloc_req && (sz != 0) && !recover;
        check("m_ready", ready, ready_e);
        check("m_state", state_dbg == FL_RUN, ready_e);
        check("m_grant", alloc_grant, grant_e);
        if (grant_e) check("m_preg", alloc_preg, exp_q[0]);
        check("m_count", free_count, sz);
        check("m_full", list_full, sz == DEPTH);
        check("m_empty", list_empty, sz == 0);
        check("m_ovf", overflow_err, m_ovf);
        if (reset_n) begin
            if (m_init_left > 0) begin
                exp_q.push_back(preg_t'(NUM_AREGS + DEPTH - m_init_left));
                m_init_left--;
            end else begin
                acc = release_valid && (sz < DEPTH);
                if (release_valid && sz == DEPTH) m_ovf = 1'b1;
                if (recover) begin
                    for (int i = spec_q.size() - 1; i >= 0; i--) exp_q.push_front(spec_q[i]);
                    spec_q.delete();
                end else begin
                    if (grant_e) spec_q.push_back(exp_q.pop_front());
                    if (ckpt_save) spec_q.delete();
                end
                if (acc) exp_q.push_back(release_preg);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();
        alloc_req = 1'b1;
        tick();
        check("rst_ready", ready, 1'b0);
        check("rst_grant", alloc_grant, 1'b0);
        check("rst_count", free_count, 0);
        check("rst_empty", list_empty, 1'b1);
        check("rst_full", list_full, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        alloc_req = 1'b0;
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("init_ready", ready, 1'b0);
            check("init_count", free_count, i);
            tick();
        end
        #1;
        check("run_ready", ready, 1'b1);
        check("run_count", free_count, 32);
        check("run_full", list_full, 1'b1);

        // First three grants come out in fill order.
        alloc_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("grant_seq", alloc_grant, 1'b1);
            check("grant_tag", alloc_preg, 32 + k);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        check("count_29", free_count, 29);

        // Drain, then an empty-list request with a same-cycle release.
        alloc_req = 1'b1;
        for (int k = 0; k < 29; k++) begin
            #1;
            check("drain_tag", alloc_preg, 35 + k);
            tick();
        end
        #1;
        check("drained_empty", list_empty, 1'b1);
        check("drained_nogrant", alloc_grant, 1'b0);
        release_valid = 1'b1;
        release_preg  = 6'd5;
        ckpt_save     = 1'b1;
        #1;
        check("nobypass_grant", alloc_grant, 1'b0);
        tick();
        release_valid = 1'b0;
        ckpt_save     = 1'b0;
        #1;
        check("freed_grant", alloc_grant, 1'b1);
        check("freed_tag", alloc_preg, 5);
        tick();
        alloc_req = 1'b0;

        // Build count=10, then allocate and release together.
        release_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            release_preg = preg_t'(40 + k);
            tick();
        end
        release_valid = 1'b0;
        #1;
        check("count_10", free_count, 10);
        alloc_req     = 1'b1;
        release_valid = 1'b1;
        release_preg  = 6'd7;
        #1;
        check("simul_tag", alloc_preg, 40);
        tick();
        release_valid = 1'b0;
        #1;
        check("simul_count", free_count, 10);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("simul_order", alloc_preg, (k < 9) ? 41 + k : 7);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        check("simul_empty", list_empty, 1'b1);

        // Fresh list: overflow, then checkpoint recovery.
        do_reset();
        repeat (DEPTH) tick();
        #1;
        check("rerun_ready", ready, 1'b1);
        release_valid = 1'b1;
        release_preg  = 6'd9;
        tick();
        release_valid = 1'b0;
        #1;
        check("ovf_set", overflow_err, 1'b1);
        check("ovf_count", free_count, 32);

        alloc_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("pre_ckpt_tag", alloc_preg, 32 + k);
            tick();
        end
        alloc_req = 1'b0;
        ckpt_save = 1'b1;
        tick();
        ckpt_save = 1'b0;
        alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("spec_tag", alloc_preg, 34 + k);
            tick();
        end
        recover       = 1'b1;
        release_valid = 1'b1;
        release_preg  = 6'd3;
        #1;
        check("recover_nogrant", alloc_grant, 1'b0);
        tick();
        recover       = 1'b0;
        release_valid = 1'b0;
        #1;
        check("recover_count", free_count, 31);
        for (int k = 0; k < 31; k++) begin
            #1;
            check("recover_order", alloc_preg, (k < 30) ? 34 + k : 3);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        check("recover_empty", list_empty, 1'b1);
        check("ovf_sticky", overflow_err, 1'b1);

        // Constrained random traffic; releases never overrun the checkpointed span.
        for (int i = 0; i < 700; i++) begin
            tick();
            alloc_req     = ($urandom_range(0, 99) < 55);
            ckpt_save     = ($urandom_range(0, 99) < 10);
            recover       = ($urandom_range(0, 99) < 6) && (spec_q.size() < DEPTH);
            release_valid = ($urandom_range(0, 99) < 50) &&
                            ((exp_q.size() + spec_q.size() < DEPTH) || (exp_q.size() == DEPTH));
            release_preg  = preg_t'($urandom_range(0, NUM_PREGS - 1));
            if (i == 350) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("async_ready", ready, 1'b0);
                check("async_grant", alloc_grant, 1'b0);
                check("async_count", free_count, 0);
                check("async_empty", list_empty, 1'b1);
                check("async_full", list_full, 1'b0);
                check("async_ovf", overflow_err, 1'b0);
                check("async_state", state_dbg == FL_INIT, 1'b1);
                idle();
                tick();
                tick();
                reset_n = 1'b1;
            end
        end
        idle();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
